// File: rtl/wpg_pkg.sv
// Shared types and helpers for the weight pattern generator.
// Optional self-check build: define WPG_SELFCHECK_EN.
package wpg_pkg;

    localparam int unsigned DefaultWidth = 7;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } wpg_state_e;

    // Number of WIDTH-bit words with exactly k ones.
    function automatic int unsigned binom(input int unsigned n, input int unsigned k);
        int unsigned r;
        if (k > n) begin
            return 0;
        end
        r = 1;
        for (int unsigned i = 0; i < k; i++) begin
            r = r * (n - i) / (i + 1);
        end
        return r;
    endfunction

    // Largest word of the enumeration: k ones packed at the top of a width-bit word.
    function automatic logic [7:0] final_pattern(input int unsigned k, input int unsigned width);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if ((i < int'(width)) && (i >= int'(width) - int'(k))) begin
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/weight_pattern_gen_if.sv
// Control and output stream of the weight pattern generator.
// The err signal exists only when WPG_SELFCHECK_EN is defined.
interface weight_pattern_gen_if
    import wpg_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned IW    = 8
);
    localparam int unsigned WW = $clog2(WIDTH + 1);

    logic             start;
    logic [WW-1:0]    weight;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pattern;
    logic             last;
    logic [IW-1:0]    index;
    logic             busy;
    logic             done;
`ifdef WPG_SELFCHECK_EN
    logic             err;
`endif

    modport master (
        input  start, weight, abort, out_ready,
        output out_valid, pattern, last, index, busy, done
`ifdef WPG_SELFCHECK_EN
        , output err
`endif
    );

    modport slave (
        output start, weight, abort, out_ready,
        input  out_valid, pattern, last, index, busy, done
`ifdef WPG_SELFCHECK_EN
        , input err
`endif
    );

endinterface

// File: rtl/wpg_next_comb.sv
// Gosper step: smallest word above x with the same number of ones.
// Evaluated on WIDTH+1 bits so the carry out of the top bit is not lost.
module wpg_next_comb #(
    parameter int unsigned WIDTH = 7
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] next
);
    localparam int unsigned TW = $clog2(WIDTH + 1);

    logic [WIDTH:0]  xe;
    logic [WIDTH:0]  c;
    logic [WIDTH:0]  r;
    logic [WIDTH:0]  d;
    logic [TW-1:0]   tz;
    logic            found;

    always_comb begin
        xe    = {1'b0, x};
        c     = xe & (~xe + 1'b1);
        r     = xe + c;
        tz    = '0;
        found = 1'b0;
        for (int i = 0; i <= int'(WIDTH); i++) begin
            if (c[i] && !found) begin
                tz    = TW'(i);
                found = 1'b1;
            end
        end
        d    = ((r ^ xe) >> 2) >> tz;
        next = WIDTH'(d | r);
    end

endmodule

// File: rtl/weight_pattern_gen.sv
// Enumerates all WIDTH-bit words of a requested weight in increasing order on a valid/ready stream.
// Define WPG_SELFCHECK_EN to add the sticky err output and its popcount/ordering checker.
module weight_pattern_gen
    import wpg_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned IW    = 8
) (
    input logic                 clk,
    input logic                 rst,
    weight_pattern_gen_if.master bus
);
    localparam int unsigned WW = $clog2(WIDTH + 1);

    wpg_state_e       state_q;
    logic [WIDTH-1:0] pattern_q;
    logic [WIDTH-1:0] final_q;
    logic             last_q;
    logic [IW-1:0]    index_q;
    logic             done_q;

    logic [WW-1:0]    k_sat;
    logic [WIDTH-1:0] init_pat;
    logic [WIDTH-1:0] init_final;
    logic [WIDTH-1:0] next_pat;

    always_comb begin
        k_sat    = (bus.weight > WW'(WIDTH)) ? WW'(WIDTH) : bus.weight;
        init_pat = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            init_pat[i] = (i < int'(k_sat));
        end
        init_final = WIDTH'(final_pattern(int'(k_sat), WIDTH));
    end

    wpg_next_comb #(
        .WIDTH (WIDTH)
    ) u_next (
        .x    (pattern_q),
        .next (next_pat)
    );

`ifdef WPG_SELFCHECK_EN
    logic [WW-1:0]    k_q;
    logic [WIDTH-1:0] prev_q;
    logic             have_prev_q;
    logic             err_q;
    logic [WW-1:0]    ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones = ones + WW'(pattern_q[i]);
        end
    end

    assign bus.err = err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pattern_q   <= '0;
            final_q     <= '0;
            last_q      <= 1'b0;
            index_q     <= '0;
            done_q      <= 1'b0;
`ifdef WPG_SELFCHECK_EN
            k_q         <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q   <= StRun;
                        pattern_q <= init_pat;
                        final_q   <= init_final;
                        last_q    <= (init_pat == init_final);
                        index_q   <= '0;
`ifdef WPG_SELFCHECK_EN
                        k_q         <= k_sat;
                        have_prev_q <= 1'b0;
                        err_q       <= 1'b0;
`endif
                    end
                end
                StRun: begin
                    // abort outranks a handshake landing on the same edge
                    if (bus.abort) begin
                        state_q <= StIdle;
                    end else if (bus.out_ready) begin
`ifdef WPG_SELFCHECK_EN
                        if ((ones != k_q) || (have_prev_q && (pattern_q <= prev_q))) begin
                            err_q <= 1'b1;
                        end
                        prev_q      <= pattern_q;
                        have_prev_q <= 1'b1;
`endif
                        if (last_q) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            pattern_q <= next_pat;
                            last_q    <= (next_pat == final_q);
                            index_q   <= index_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RUN always holds a presentable word, so valid and busy are the state flop itself.
    assign bus.out_valid = (state_q == StRun);
    assign bus.busy      = (state_q == StRun);
    assign bus.pattern   = pattern_q;
    assign bus.last      = last_q;
    assign bus.index     = index_q;
    assign bus.done      = done_q;

endmodule
